// File: rtl/prim_hold_driver_pkg.sv
// Shared types for the minimum-hold output driver.
package prim_hold_driver_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/prim_hold_cnt.sv
// Loadable down-counter that tracks the remaining cycles of a hold window.
module prim_hold_cnt #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A load wins over a decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prim_hold_driver.sv
// Drives an output level and holds every driven value for at least MinHold cycles;
// transparent bypass while enable_i is low.
module prim_hold_driver
  import prim_hold_driver_pkg::*;
#(
  parameter  int unsigned MinHold = 4,
  localparam int unsigned CntW    = $clog2(MinHold + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic level_i,
  output logic level_o,
  output logic busy_o,
  output logic drop_o
);

  localparam logic [CntW-1:0] LoadVal = CntW'(MinHold - 1);

  hold_state_e     state_q, state_d;
  logic            out_q, out_d;
  logic            pend_q, pend_d;
  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_dec;
  logic            cnt_zero;
  logic            drop;
  logic            diff;

  assign diff = (level_i != out_q);

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    pend_d       = pend_q;
    cnt_load     = 1'b0;
    cnt_load_val = LoadVal;
    cnt_dec      = 1'b0;
    drop         = 1'b0;
    if (!enable_i) begin
      // Track the input so a later re-enable starts without a glitch.
      out_d        = level_i;
      state_d      = ST_IDLE;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      pend_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (diff) begin
            out_d    = level_i;
            cnt_load = 1'b1;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
            if (diff) begin
              pend_d = 1'b1;
            end else if (pend_q) begin
              drop   = 1'b1;
              pend_d = 1'b0;
            end
          end else begin
            // Last hold cycle: a differing request is taken back-to-back.
            pend_d = 1'b0;
            if (diff) begin
              out_d    = level_i;
              cnt_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              drop    = pend_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
    end
  end

  prim_hold_cnt #(
    .CntW(CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign level_o = enable_i ? out_q : level_i;
  assign busy_o  = enable_i & (state_q == ST_HOLD);
  assign drop_o  = drop;

endmodule
